multicycle_sequencer: RTL and testbench

//  Multicycle control FSM for the 4-bit core: sequences fetch, decode, execute, memory and writeback over shared

---
 rtl/multicycle_sequencer.sv | 176 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the 4-bit core: fetch/decode/exec/mem/writeback over req/ack memories.
// Optional single-step control (step_mode/step ports) is enabled by defining SEQ_SINGLE_STEP_EN.
module multicycle_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         funct,
  input  logic               cond_true,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               ir_load,
  output logic               dmem_req,
  output logic               dmem_we,
  input  logic               dmem_ack,
  output logic               mdr_load,
  output logic               rf_we,
  output logic [1:0]         rf_wsrc,
  output logic               alu_srca,
  output logic               alu_sub,
  output logic               pc_en,
  output logic               pc_sel,
  output logic               halted,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  // A wait cycle seen while the counter holds WaitLast is the one that reaches the limit.
  localparam logic [7:0] WaitLast = 8'(ACK_TIMEOUT - 1);

  state_e             state_q, state_d;
  state_e             retire_st;
  logic [7:0]         wait_q, wait_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               start_ok;
  logic               op_halt, op_setn, op_load, op_store, op_alu, op_branch, op_jump;

  assign op_halt   = (funct == 4'b0000);
  assign op_setn   = (funct == 4'b0001);
  assign op_load   = (funct == 4'b0010);
  assign op_store  = (funct == 4'b0011);
  assign op_alu    = (funct[3:2] == 2'b01);
  assign op_branch = (funct[3:2] == 2'b10);
  assign op_jump   = (funct[3:2] == 2'b11);

`ifdef SEQ_SINGLE_STEP_EN
  assign start_ok  = ~step_mode | step;
  assign retire_st = step_mode ? StIdle : StFetch;
`else
  assign start_ok  = 1'b1;
  assign retire_st = StFetch;
`endif

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    mdr_load = 1'b0;
    rf_we    = 1'b0;
    rf_wsrc  = 2'b00;
    alu_srca = 1'b0;
    alu_sub  = 1'b0;
    pc_en    = 1'b0;
    pc_sel   = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (wait_q == WaitLast) begin
          state_d = StFault;
        end
      end
      StDecode: begin
        state_d = op_halt ? StHalt : StExec;
      end
      StExec: begin
        if (op_alu) begin
          alu_srca = 1'b1;
          alu_sub  = funct[0];
          state_d  = StWb;
        end else if (op_setn) begin
          state_d = StWb;
        end else if (op_load || op_store) begin
          state_d = StMem;
        end else if (op_branch) begin
          pc_en   = 1'b1;
          pc_sel  = cond_true;
          state_d = retire_st;
        end else if (op_jump) begin
          pc_en   = 1'b1;
          pc_sel  = 1'b1;
          state_d = retire_st;
        end else begin
          state_d = StHalt;
        end
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = op_store;
        if (dmem_ack) begin
          if (op_store) begin
            pc_en   = 1'b1;
            state_d = retire_st;
          end else begin
            mdr_load = 1'b1;
            state_d  = StWb;
          end
        end else if (wait_q == WaitLast) begin
          state_d = StFault;
        end
      end
      StWb: begin
        rf_we    = 1'b1;
        rf_wsrc  = op_load ? 2'b01 : (op_setn ? 2'b10 : 2'b00);
        alu_srca = op_alu;
        alu_sub  = op_alu & funct[0];
        pc_en    = 1'b1;
        state_d  = retire_st;
      end
      StHalt:  halted = 1'b1;
      StFault: fault  = 1'b1;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wait_d = 8'd0;
    if ((state_d == state_q) && ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))) begin
      wait_d = wait_q + 8'd1;
    end
    retired_d = retired_q;
    if (pc_en && (retired_q != {COUNT_W{1'b1}})) retired_d = retired_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus a randomized program
// checked against a per-instruction trace model; a second instance with a 2-bit retire counter.
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [3:0]  funct = 4'd0;
  logic        cond_true = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic        step_mode = 1'b0, step = 1'b0;
`endif
  logic        imem_req, ir_load, dmem_req, dmem_we, mdr_load, rf_we, alu_srca, alu_sub;
  logic        pc_en, pc_sel, halted, fault;
  logic [1:0]  rf_wsrc;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        s_imem_req, s_ir_load, s_dmem_req, s_dmem_we, s_mdr_load, s_rf_we, s_alu_srca;
  logic        s_alu_sub, s_pc_en, s_pc_sel, s_halted, s_fault;
  logic [1:0]  s_rf_wsrc, s_retired;
  logic [2:0]  s_state;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_sequencer #(.ACK_TIMEOUT(15), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .funct(funct), .cond_true(cond_true),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .mdr_load(mdr_load), .rf_we(rf_we),
    .rf_wsrc(rf_wsrc), .alu_srca(alu_srca), .alu_sub(alu_sub), .pc_en(pc_en), .pc_sel(pc_sel),
    .halted(halted), .fault(fault), .state(state), .retired(retired)
  );

  multicycle_sequencer #(.ACK_TIMEOUT(15), .COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .funct(funct), .cond_true(cond_true),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .imem_req(s_imem_req), .imem_ack(imem_ack), .ir_load(s_ir_load), .dmem_req(s_dmem_req),
    .dmem_we(s_dmem_we), .dmem_ack(dmem_ack), .mdr_load(s_mdr_load), .rf_we(s_rf_we),
    .rf_wsrc(s_rf_wsrc), .alu_srca(s_alu_srca), .alu_sub(s_alu_sub), .pc_en(s_pc_en),
    .pc_sel(s_pc_sel), .halted(s_halted), .fault(s_fault), .state(s_state), .retired(s_retired)
  );

  // One expected clock cycle: inputs to drive and the outputs the specification requires.
  // strobes = {imem_req, ir_load, dmem_req, we, mdr_load, rf_we, wsrc[1:0], pc_en, pc_sel, halt, fault}
  typedef struct {
    logic [2:0]  st;
    logic [3:0]  fn;
    logic        cond, iack, dack, chk_alu, srca, sub;
    logic [11:0] strobes;
  } step_t;

  step_t trace[$];

  function automatic logic [11:0] strb(input logic ireq, input logic irl, input logic dreq,
                                       input logic we, input logic mdr, input logic rfwe,
                                       input logic [1:0] ws, input logic pce, input logic pcs);
    return {ireq, irl, dreq, we, mdr, rfwe, ws, pce, pcs, 2'b00};
  endfunction

  function automatic step_t blank(input logic [2:0] st, input logic [3:0] f, input logic c);
    step_t s;
    s.st = st; s.fn = f; s.cond = c;
    s.iack = 1'($urandom_range(0, 1));
    s.dack = 1'($urandom_range(0, 1));
    s.chk_alu = 1'b0; s.srca = 1'b0; s.sub = 1'b0;
    s.strobes = '0;
    return s;
  endfunction

  // Model: one instruction expands to its state/strobe trace with iw/dw wait cycles.
  task automatic add_instr(input logic [3:0] f, input int iw, input int dw, input logic c);
    step_t s;
    logic  ld, stq, alu, setn, br, jmp;
    ld = (f == 4'd2); stq = (f == 4'd3); setn = (f == 4'd1);
    alu = (f >= 4'd4 && f <= 4'd7); br = (f >= 4'd8 && f <= 4'd11); jmp = (f >= 4'd12);
    for (int k = 0; k <= iw; k++) begin
      s = blank(3'd1, f, c);
      s.iack = (k == iw);
      s.strobes = strb(1'b1, k == iw, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
      trace.push_back(s);
    end
    trace.push_back(blank(3'd2, f, c));
    s = blank(3'd3, f, c);
    if (alu) begin s.chk_alu = 1'b1; s.srca = 1'b1; s.sub = f[0]; end
    if (br || jmp) s.strobes = strb(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, jmp | c);
    trace.push_back(s);
    if (ld || stq) begin
      for (int k = 0; k <= dw; k++) begin
        s = blank(3'd4, f, c);
        s.dack = (k == dw);
        s.strobes = strb(1'b0, 1'b0, 1'b1, stq, ld && k == dw, 1'b0, 2'b00, stq && k == dw, 1'b0);
        trace.push_back(s);
      end
    end
    if (alu || setn || ld) begin
      s = blank(3'd5, f, c);
      if (alu) begin s.chk_alu = 1'b1; s.srca = 1'b1; s.sub = f[0]; end
      s.strobes = strb(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ld ? 2'b01 : (setn ? 2'b10 : 2'b00),
                       1'b1, 1'b0);
      trace.push_back(s);
    end
  endtask

  // Leaves the bench at a negedge with the DUT in IDLE.
  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; cond_true = 1'b0; funct = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({imem_req, ir_load, dmem_req, dmem_we, mdr_load, rf_we, rf_wsrc, alu_srca, alu_sub,
         pc_en, pc_sel, halted, fault, state} !== 17'd0)
      $display("FAIL reset_outputs got state=%0d req=%b want all zero", state, imem_req);
    else n_pass++;
    n_checks++;
    if (retired !== 16'd0) $display("FAIL reset_retired got %0d want 0", retired);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if ({state, imem_req} !== {3'd1, 1'b1})
      $display("FAIL reset_to_fetch got state=%0d req=%b want 1/1", state, imem_req);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if ({state, imem_req} !== {3'd0, 1'b0})
      $display("FAIL midop_reset got state=%0d req=%b want 0/0", state, imem_req);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_alu();
    int exp_st[6] = '{0, 1, 2, 3, 5, 1};
    do_reset();
    funct = 4'b0101; imem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (state !== 3'(exp_st[i])) $display("FAIL alu_state[%0d] got %0d want %0d", i, state, exp_st[i]);
      else n_pass++;
      if (i == 3) begin
        n_checks++;
        if (alu_srca !== 1'b1) $display("FAIL alu_srca got %b want 1", alu_srca);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if ({rf_we, rf_wsrc, alu_sub, pc_en, pc_sel} !== 6'b100110)
          $display("FAIL alu_wb got %b want 100110", {rf_we, rf_wsrc, alu_sub, pc_en, pc_sel});
        else n_pass++;
      end
      if (i == 4 || i == 5) begin
        n_checks++;
        if (retired !== 16'(i - 4)) $display("FAIL alu_retired got %0d want %0d", retired, i - 4);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    int exp_st[10] = '{0, 1, 2, 3, 4, 4, 4, 4, 5, 1};
    int mdr_cnt = 0;
    do_reset();
    funct = 4'b0010; imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dmem_ack = (i == 7);
      #1;
      n_checks++;
      if (state !== 3'(exp_st[i])) $display("FAIL load_state[%0d] got %0d want %0d", i, state, exp_st[i]);
      else n_pass++;
      if (mdr_load) mdr_cnt++;
      if (i >= 4 && i <= 7) begin
        n_checks++;
        if ({dmem_req, dmem_we} !== 2'b10) $display("FAIL load_mem[%0d] got %b want 10", i, {dmem_req, dmem_we});
        else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if ({rf_we, rf_wsrc} !== 3'b101) $display("FAIL load_wb got %b want 101", {rf_we, rf_wsrc});
        else n_pass++;
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    n_checks++;
    if (mdr_cnt != 1) $display("FAIL load_mdr_pulses got %0d want 1", mdr_cnt);
    else n_pass++;
    n_checks++;
    if (retired !== 16'd1) $display("FAIL load_retired got %0d want 1", retired);
    else n_pass++;
  endtask

  task automatic test_branch();
    int exp_st[8] = '{0, 1, 2, 3, 1, 2, 3, 1};
    do_reset();
    funct = 4'b1010; imem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cond_true = (i >= 4);
      #1;
      n_checks++;
      if ({state, rf_we} !== {3'(exp_st[i]), 1'b0})
        $display("FAIL branch_state[%0d] got %0d/%b want %0d/0", i, state, rf_we, exp_st[i]);
      else n_pass++;
      if (i == 3 || i == 6) begin
        n_checks++;
        if ({pc_en, pc_sel} !== {1'b1, cond_true})
          $display("FAIL branch_pc[%0d] got %b want 1%b", i, {pc_en, pc_sel}, cond_true);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (retired !== 16'd2) $display("FAIL branch_retired got %0d want 2", retired);
    else n_pass++;
  endtask

  task automatic test_halt();
    int exp_st[7] = '{0, 1, 2, 3, 1, 2, 6};
    do_reset();
    imem_ack = 1'b1;
    for (int i = 0; i < 7; i++) begin
      funct = (i < 4) ? 4'b1100 : 4'b0000;
      #1;
      n_checks++;
      if (state !== 3'(exp_st[i])) $display("FAIL halt_state[%0d] got %0d want %0d", i, state, exp_st[i]);
      else n_pass++;
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if ({state, halted, imem_req, dmem_req} !== 6'b110100)
        $display("FAIL halt_hold[%0d] got %b want 110100", i, {state, halted, imem_req, dmem_req});
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if (retired !== 16'd1) $display("FAIL halt_retired got %0d want 1", retired);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({state, halted, retired} !== 20'd0)
      $display("FAIL halt_reset got state=%0d halted=%b retired=%0d want 0", state, halted, retired);
    else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      n_checks++;
      if ({state, imem_req} !== ((i == 0) ? 4'b0000 : 4'b0011))
        $display("FAIL timeout_wait[%0d] got %0d/%b", i, state, imem_req);
      else n_pass++;
      @(negedge clk);
    end
    imem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if ({state, fault, imem_req} !== 5'b11110)
        $display("FAIL timeout_fault[%0d] got %b want 11110", i, {state, fault, imem_req});
      else n_pass++;
      @(negedge clk);
    end
    do_reset();
    for (int i = 0; i < 17; i++) begin
      imem_ack = (i == 15);
      #1;
      if (i == 15 || i == 16) begin
        n_checks++;
        if ({state, fault} !== ((i == 15) ? 4'b0010 : 4'b0100))
          $display("FAIL timeout_late_ack[%0d] got %0d/%b", i, state, fault);
        else n_pass++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_program();
    step_t       s;
    logic [11:0] act;
    int          exp_ret = 0;
    do_reset();
    trace.delete();
    trace.push_back(blank(3'd0, 4'd1, 1'b0));
    for (int n = 0; n < 30; n++)
      add_instr(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    foreach (trace[i]) begin
      s = trace[i];
      funct = s.fn; cond_true = s.cond; imem_ack = s.iack; dmem_ack = s.dack;
      #1;
      act = {imem_req, ir_load, dmem_req, dmem_req & dmem_we, mdr_load, rf_we,
             rf_we ? rf_wsrc : 2'b00, pc_en, pc_en & pc_sel, halted, fault};
      n_checks++;
      if (state !== s.st) $display("FAIL rand_state[%0d] got %0d want %0d", i, state, s.st);
      else n_pass++;
      n_checks++;
      if (act !== s.strobes) $display("FAIL rand_strobes[%0d] got %b want %b", i, act, s.strobes);
      else n_pass++;
      if (s.chk_alu) begin
        n_checks++;
        if ({alu_srca, alu_sub} !== {s.srca, s.sub})
          $display("FAIL rand_alu[%0d] got %b want %b", i, {alu_srca, alu_sub}, {s.srca, s.sub});
        else n_pass++;
      end
      n_checks++;
      if (retired !== 16'(exp_ret)) $display("FAIL rand_retired[%0d] got %0d want %0d", i, retired, exp_ret);
      else n_pass++;
      n_checks++;
      if (s_retired !== 2'((exp_ret > 3) ? 3 : exp_ret))
        $display("FAIL rand_saturate[%0d] got %0d want %0d", i, s_retired, (exp_ret > 3) ? 3 : exp_ret);
      else n_pass++;
      if (s.strobes[3]) exp_ret++;
      @(negedge clk);
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    do_reset();
    step_mode = 1'b1; funct = 4'b1100; imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (state !== 3'd0) $display("FAIL step_idle_wait got %0d want 0", state);
      else n_pass++;
      @(negedge clk);
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      #1;
      n_checks++;
      if (state !== 3'd1) $display("FAIL step_fetch[%0d] got %0d want 1", p, state);
      else n_pass++;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        #1;
        n_checks++;
        if (state !== 3'd0) $display("FAIL step_idle[%0d] got %0d want 0", p, state);
        else n_pass++;
        @(negedge clk);
      end
    end
    n_checks++;
    if (retired !== 16'd3) $display("FAIL step_retired got %0d want 3", retired);
    else n_pass++;
    step_mode = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_halt();
    test_timeout();
    test_random_program();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
